key_expansion_multi: RTL and testbench
======================================

KEY_EXPANSION_MULTI -- requirements
Module: key_expansion_multi

Interface
REQ-001 SHALL have parameter WORDS_PER_CYCLE_P, default 1: 32-bit schedule words generated per cycle; legal values 1, 2, 4.
REQ-002 SHALL have the ports below, in this order:
- clk_i  input  1  the single clock.
- reset_n_i  input  1  reset; asynchronous, active-low.
- key_i  input  [0:255]  cipher key, MSB-first.
  - AES-128 uses bits [0:127]; AES-192 uses bits [0:191]; remaining bits ignored.
- key_len_i  input  2  key length: 00=128, 01=192, 10=256, 11=illegal.
- v_i  input  1  request valid.
- ready_o  output  1  block can accept a request.
- round_keys_o  output  [0:128*15-1]  round keys, round 0 at bits [0:127]; unused rounds are zero.
- num_rounds_o  output  4  Nr of the latched job: 10, 12 or 14.
- err_o  output  1  latched job had key_len_i=11.
- v_o  output  1  result valid.
- yumi_i  input  1  consumer takes the result.
- dec_i  input  1  equivalent-inverse schedule request; port present only under KEY_EXPANSION_INV_EN.

Function
REQ-003 SHALL accept a request on the rising clk_i edge where v_i & ready_o; key_i, key_len_i (and dec_i) latched that edge.
REQ-004 SHALL implement states IDLE, EXPAND, DONE (plus FIX under config).
- IDLE->EXPAND on accept.
- EXPAND->DONE after the last word.
- DONE->IDLE on yumi_i.
REQ-005 SHALL assert ready_o only in IDLE, and v_o only in DONE.
REQ-006 SHALL hold v_o, round_keys_o, num_rounds_o and err_o stable in DONE until yumi_i; yumi_i outside DONE is ignored.
REQ-007 SHALL load w[0..Nk-1] from the key on accept (Nk = 4/6/8) and zero all other words.
REQ-008 SHALL generate w[i] for i = Nk..4(Nr+1)-1 per FIPS-197, WORDS_PER_CYCLE_P words per EXPAND cycle, each lane computing its own i mod Nk.
- i mod Nk = 0: RotWord, SubWord, Rcon.
- AES-256 with i mod 8 = 4: SubWord only.
REQ-009 SHALL discard lane results beyond the final word index in the last EXPAND cycle.
REQ-010 SHALL take EXPAND cycles = ceil((4(Nr+1)-Nk)/WORDS_PER_CYCLE_P).
- 128: 40/20/10.
- 192: 46/23/12.
- 256: 52/26/13.
- v_o rises the cycle after the last EXPAND cycle.
REQ-011 SHALL use a Rcon sequence 01,02,04,08,10,20,40,80,1b,36 indexed by i/Nk.
REQ-012 SHALL, for key_len_i=11, skip EXPAND, enter DONE the cycle after accept with err_o=1, round_keys_o all zero, num_rounds_o=0.
REQ-013 SHALL accept no new request in the cycle of yumi_i; earliest next accept is the following cycle.
REQ-014 SHALL keep round_keys_o updating visibly during EXPAND; its value is only guaranteed while v_o=1.

Reset
REQ-015 SHALL, on reset_n_i=0, immediately enter IDLE: ready_o=1, v_o=0, err_o=0, num_rounds_o=0, round_keys_o all zero.
REQ-016 SHALL abort any in-flight EXPAND/FIX/DONE job on reset assertion; the job is lost, with no v_o pulse.
REQ-017 SHALL accept no request in the first clk_i edge coinciding with reset release.

Configuration
REQ-018 SHALL, with macro KEY_EXPANSION_INV_EN defined, expose dec_i and add state FIX.
- FIX is entered after EXPAND when the latched dec_i=1.
- FIX applies InvMixColumns to round keys 1..Nr-1, one round key per cycle: Nr-1 extra cycles.
- Rounds 0 and Nr are unchanged.
- dec_i=0 behaves as without the macro.
REQ-019 SHALL, without KEY_EXPANSION_INV_EN, have no dec_i port, no FIX state, and no InvMixColumns logic.

Verification
REQ-020 AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, P=1:
- v_o exactly 41 cycles after accept.
- w[43]=b6630ca6; num_rounds_o=10; rounds 11-14 zero.
REQ-021 FIPS-197 C keys 000102..0f / ..17 / ..1f, each at P=1, 2, 4:
- last round key = 13111d7fe3944a17f307a78b4d2b30c5 / a4970a331a78dc09c418c271e3a41d5d / 24fc79ccbf0979e9371ac23c6d68de36.
- latency per REQ-010.
REQ-022 Back-pressure:
- hold yumi_i=0 for 20 cycles in DONE -> v_o and outputs stable, ready_o=0, new v_i ignored.
- yumi_i=1 -> ready_o=1 next cycle.
REQ-023 key_len_i=11 -> v_o one cycle after accept, err_o=1, round_keys_o=0, num_rounds_o=0.
REQ-024 reset_n_i low mid-EXPAND (AES-256, cycle 20):
- outputs zero and ready_o=1 immediately.
- a following AES-128 request completes correctly.
REQ-025 With KEY_EXPANSION_INV_EN, AES-128 key 000102..0f, dec_i=1:
- v_o 50 cycles after accept.
- round 10 = 13111d7fe3944a17f307a78b4d2b30c5; round 0 = key.
- rounds 1-9 = InvMixColumns of the encrypt keys.

Source files
------------

// File: rtl/key_expansion_multi.sv
// rtl/key_expansion_multi.sv - AES key schedule generator producing WORDS_PER_CYCLE_P words per cycle
//
// Purpose: expands a 128/192/256-bit AES key into all round keys (FIPS-197
// key expansion). A request is accepted when v_i & ready_o. The schedule is
// generated over several cycles. The result is then held with v_o=1 until
// the consumer pulses yumi_i.
//
// Optional feature, guarded by macro KEY_EXPANSION_INV_EN: adds port dec_i
// and a FIX state. FIX applies InvMixColumns to round keys 1..Nr-1, which
// gives the equivalent-inverse-cipher schedule.
//
// Ports:
//   clk_i         clock
//   reset_n_i     asynchronous active-low reset
//   key_i         cipher key, MSB-first (bits [0:127]/[0:191]/[0:255] used)
//   key_len_i     00=AES-128, 01=AES-192, 10=AES-256, 11=illegal
//   v_i           request valid
//   ready_o       block idle and able to accept a request
//   round_keys_o  round keys, round 0 at bits [0:127], unused rounds zero
//   num_rounds_o  Nr of the latched job (10/12/14, 0 for illegal)
//   err_o         latched job had key_len_i=11
//   v_o           result valid
//   yumi_i        consumer takes the result
//   dec_i         equivalent-inverse request (KEY_EXPANSION_INV_EN only)

module key_expansion_multi #(
    parameter int WORDS_PER_CYCLE_P = 1
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic [0:255]      key_i,
    input  logic [1:0]        key_len_i,
    input  logic              v_i,
    output logic              ready_o,
    output logic [0:128*15-1] round_keys_o,
    output logic [3:0]        num_rounds_o,
    output logic              err_o,
    output logic              v_o,
    input  logic              yumi_i
`ifdef KEY_EXPANSION_INV_EN
    ,
    input  logic              dec_i
`endif
);

    localparam int P = WORDS_PER_CYCLE_P;

`ifdef KEY_EXPANSION_INV_EN
    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE, S_FIX} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;
`endif

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (b^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = gf_mul(b, b);
        for (int k = 1; k < 8; k++) begin
            inv = gf_mul(inv, sq);
            sq  = gf_mul(sq, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] v);
        return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] d);
        case (d)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One schedule word: w[i] = w[i-Nk] ^ f(w[i-1]).
    function automatic logic [31:0] next_word(input logic [5:0] i, input logic [31:0] temp,
                                              input logic [31:0] prev, input logic [1:0] klen);
        logic [5:0]  m;
        logic [3:0]  d;
        logic [31:0] t;
        case (klen)
            2'b00: begin
                m = {4'd0, i[1:0]};
                d = i[5:2];
            end
            2'b01: begin
                m = i % 6'd6;
                d = 4'(i / 6'd6);
            end
            default: begin
                m = {3'd0, i[2:0]};
                d = {1'b0, i[5:3]};
            end
        endcase
        t = temp;
        if (m == 6'd0) begin
            t = sub_word({temp[23:0], temp[31:24]}) ^ {rcon(d), 24'h000000};
        end else if (klen == 2'b10 && m == 6'd4) begin
            t = sub_word(temp);
        end
        return prev ^ t;
    endfunction

`ifdef KEY_EXPANSION_INV_EN
    function automatic logic [31:0] inv_mix_word(input logic [31:0] v);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = v;
        return {gf_mul(b0, 8'h0e) ^ gf_mul(b1, 8'h0b) ^ gf_mul(b2, 8'h0d) ^ gf_mul(b3, 8'h09),
                gf_mul(b0, 8'h09) ^ gf_mul(b1, 8'h0e) ^ gf_mul(b2, 8'h0b) ^ gf_mul(b3, 8'h0d),
                gf_mul(b0, 8'h0d) ^ gf_mul(b1, 8'h09) ^ gf_mul(b2, 8'h0e) ^ gf_mul(b3, 8'h0b),
                gf_mul(b0, 8'h0b) ^ gf_mul(b1, 8'h0d) ^ gf_mul(b2, 8'h09) ^ gf_mul(b3, 8'h0e)};
    endfunction
`endif

    state_t      state_q, state_d;
    logic        armed_q;
    logic [31:0] w_q [60];
    logic [5:0]  idx_q;
    logic [5:0]  nk_q;
    logic [5:0]  total_q;
    logic [1:0]  klen_q;
    logic [3:0]  nr_q;
    logic        err_q;
`ifdef KEY_EXPANSION_INV_EN
    logic        dec_q;
    logic [3:0]  fix_r_q;
`endif

    logic        accept;
    logic        last_expand;
    logic [5:0]  nk_new;
    logic [3:0]  nr_new;
    logic [5:0]  lane_idx [P];
    logic [31:0] lane_w   [P];

    // armed_q blocks an accept on the first edge after reset release.
    assign accept      = v_i & ready_o & armed_q;
    assign last_expand = (7'(idx_q) + 7'(P)) >= 7'(total_q);

    always_comb begin
        nk_new = 6'd0;
        nr_new = 4'd0;
        case (key_len_i)
            2'b00: begin nk_new = 6'd4; nr_new = 4'd10; end
            2'b01: begin nk_new = 6'd6; nr_new = 4'd12; end
            2'b10: begin nk_new = 6'd8; nr_new = 4'd14; end
            default: ;
        endcase
    end

    // Lanes are chained: lane l uses lane l-1's word as its w[i-1]. Since
    // P <= Nk, w[i-Nk] always comes from already stored words.
    always_comb begin
        logic [31:0] t;
        t = w_q[idx_q - 6'd1];
        for (int l = 0; l < P; l++) begin
            lane_idx[l] = idx_q + 6'(l);
            lane_w[l]   = next_word(lane_idx[l], t, w_q[lane_idx[l] - nk_q], klen_q);
            t           = lane_w[l];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = (key_len_i == 2'b11) ? S_DONE : S_EXPAND;
            end
            S_EXPAND: begin
`ifdef KEY_EXPANSION_INV_EN
                if (last_expand) state_d = dec_q ? S_FIX : S_DONE;
`else
                if (last_expand) state_d = S_DONE;
`endif
            end
`ifdef KEY_EXPANSION_INV_EN
            S_FIX: begin
                if (fix_r_q == nr_q - 4'd1) state_d = S_DONE;
            end
`endif
            S_DONE: begin
                if (yumi_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int j = 0; j < 60; j++) w_q[j] <= '0;
            idx_q   <= '0;
            nk_q    <= '0;
            total_q <= '0;
            klen_q  <= '0;
            nr_q    <= '0;
            err_q   <= 1'b0;
`ifdef KEY_EXPANSION_INV_EN
            dec_q   <= 1'b0;
            fix_r_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        for (int j = 0; j < 60; j++) w_q[j] <= '0;
                        for (int j = 0; j < 8; j++) begin
                            if (6'(j) < nk_new) w_q[j] <= key_i[32*j +: 32];
                        end
                        idx_q   <= nk_new;
                        nk_q    <= nk_new;
                        total_q <= {nr_new, 2'b00} + 6'd4;
                        klen_q  <= key_len_i;
                        nr_q    <= nr_new;
                        err_q   <= (key_len_i == 2'b11);
`ifdef KEY_EXPANSION_INV_EN
                        dec_q   <= dec_i;
                        fix_r_q <= 4'd1;
`endif
                    end
                end
                S_EXPAND: begin
                    // Lanes past the final word index are dropped.
                    for (int l = 0; l < P; l++) begin
                        if (lane_idx[l] < total_q) w_q[lane_idx[l]] <= lane_w[l];
                    end
                    idx_q <= idx_q + 6'(P);
                end
`ifdef KEY_EXPANSION_INV_EN
                S_FIX: begin
                    for (int k = 0; k < 4; k++) begin
                        w_q[{fix_r_q, 2'b00} + 6'(k)] <= inv_mix_word(w_q[{fix_r_q, 2'b00} + 6'(k)]);
                    end
                    fix_r_q <= fix_r_q + 4'd1;
                end
`endif
                default: ;
            endcase
        end
    end

    generate
        for (genvar j = 0; j < 60; j++) begin : g_rk
            assign round_keys_o[32*j +: 32] = w_q[j];
        end
    endgenerate

    assign ready_o      = (state_q == S_IDLE);
    assign v_o          = (state_q == S_DONE);
    assign err_o        = err_q;
    assign num_rounds_o = nr_q;

endmodule

// File: tb/tb_key_expansion_multi.sv
// tb/tb_key_expansion_multi.sv - self-checking bench for key_expansion_multi at P=1,2,4
`timescale 1ns/1ps

module tb_key_expansion_multi;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          reset_n_i;
    logic [0:255]  key_i;
    logic [1:0]    key_len_i;
    logic          v_i;
    logic          yumi_i;
`ifdef KEY_EXPANSION_INV_EN
    logic          dec_i;
`endif
    logic          ready_o [3];
    logic          v_o     [3];
    logic          err_o   [3];
    logic [3:0]    nr_o    [3];
    logic [0:1919] rk_o    [3];

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            key_expansion_multi #(.WORDS_PER_CYCLE_P(1 << g)) dut (
                .clk_i       (clk_i),
                .reset_n_i   (reset_n_i),
                .key_i       (key_i),
                .key_len_i   (key_len_i),
                .v_i         (v_i),
                .ready_o     (ready_o[g]),
                .round_keys_o(rk_o[g]),
                .num_rounds_o(nr_o[g]),
                .err_o       (err_o[g]),
                .v_o         (v_o[g]),
                .yumi_i      (yumi_i)
`ifdef KEY_EXPANSION_INV_EN
                ,
                .dec_i       (dec_i)
`endif
            );
        end
    endgenerate

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [0:2047] sbox_tbl;
    logic [31:0]   mw [60];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input int c);
        logic [7:0] acc;
        logic [7:0] pw;
        acc = 8'h00;
        pw  = a;
        for (int k = 0; k < 4; k++) begin
            if (((c >> k) & 1) == 1) acc ^= pw;
            pw = xt(pw);
        end
        return acc;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] v);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = sbox_tbl[8*int'(v[8*k +: 8]) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] imc(input logic [31:0] v);
        int         coef [4] = '{14, 11, 13, 9};
        logic [7:0] a    [4];
        logic [7:0] o;
        logic [31:0] r;
        for (int k = 0; k < 4; k++) a[k] = v[31 - 8*k -: 8];
        for (int row = 0; row < 4; row++) begin
            o = 8'h00;
            for (int k = 0; k < 4; k++) o ^= gmul(a[k], coef[(k - row + 4) % 4]);
            r[31 - 8*row -: 8] = o;
        end
        return r;
    endfunction

    task automatic model(input logic [0:255] key, input logic [1:0] klen, input logic dec);
        int nk, nr;
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 60; i++) mw[i] = '0;
        if (klen == 2'b11) return;
        nk = 4 + 2 * int'(klen);
        nr = nk + 6;
        for (int i = 0; i < nk; i++) mw[i] = key[32*i +: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = mw[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int k = 1; k < i / nk; k++) rc = xt(rc);
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            mw[i] = mw[i-nk] ^ t;
        end
        if (dec) begin
            for (int r = 1; r < nr; r++)
                for (int c = 0; c < 4; c++) mw[4*r+c] = imc(mw[4*r+c]);
        end
    endtask

    function automatic logic [127:0] fold(input logic [0:1919] v);
        logic [127:0] f;
        f = '0;
        for (int r = 0; r < 15; r++) f ^= v[128*r +: 128];
        return f;
    endfunction

    // ---------------- job helpers ----------------
    task automatic run_job(input logic [0:255] key, input logic [1:0] klen, input logic dec,
                           input string tag);
        int lat [3];
        int cnt, nk, nr, exp_lat, p;
        model(key, klen, dec);
        @(negedge clk_i);
        for (int g = 0; g < 3; g++) check($sformatf("%s ready before accept P%0d", tag, 1 << g), 128'(ready_o[g]), 128'(1));
        key_i = key;
        key_len_i = klen;
        v_i = 1'b1;
`ifdef KEY_EXPANSION_INV_EN
        dec_i = dec;
`endif
        @(posedge clk_i);
        #1;
        v_i = 1'b0;
        for (int g = 0; g < 3; g++) lat[g] = 0;
        cnt = 1;
        while (cnt <= 100) begin
            for (int g = 0; g < 3; g++) if (v_o[g] && lat[g] == 0) lat[g] = cnt;
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
            @(posedge clk_i);
            #1;
            cnt++;
        end
        nk = 4 + 2 * int'(klen);
        nr = (klen == 2'b11) ? 0 : nk + 6;
        for (int g = 0; g < 3; g++) begin
            p = 1 << g;
            if (klen == 2'b11) exp_lat = 1;
            else exp_lat = 1 + (4 * (nr + 1) - nk + p - 1) / p + (dec ? nr - 1 : 0);
            check($sformatf("%s latency P%0d", tag, p), 128'(lat[g]), 128'(exp_lat));
            for (int r = 0; r < 15; r++)
                check($sformatf("%s P%0d round %0d", tag, p, r), rk_o[g][128*r +: 128],
                      {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]});
            check($sformatf("%s num_rounds P%0d", tag, p), 128'(nr_o[g]), 128'(nr));
            check($sformatf("%s err P%0d", tag, p), 128'(err_o[g]), 128'(klen == 2'b11));
        end
    endtask

    task automatic release_job(input string tag);
        @(negedge clk_i);
        yumi_i = 1'b1;
        @(posedge clk_i);
        #1;
        yumi_i = 1'b0;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("%s ready after yumi P%0d", tag, 1 << g), 128'(ready_o[g]), 128'(1));
            check($sformatf("%s v_o after yumi P%0d", tag, 1 << g), 128'(v_o[g]), 128'(0));
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("%s ready P%0d", tag, 1 << g), 128'(ready_o[g]), 128'(1));
            check($sformatf("%s v_o P%0d", tag, 1 << g), 128'(v_o[g]), 128'(0));
            check($sformatf("%s err P%0d", tag, 1 << g), 128'(err_o[g]), 128'(0));
            check($sformatf("%s nr P%0d", tag, 1 << g), 128'(nr_o[g]), 128'(0));
            check($sformatf("%s keys P%0d", tag, 1 << g), fold(rk_o[g]), 128'(0));
        end
    endtask

    typedef struct {
        logic [0:255] key;
        logic [1:0]   klen;
        logic [127:0] last;
    } vec_t;

    localparam logic [127:0] C128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [191:0] C192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] C256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t         vecs [5];
        logic [127:0] snap [3];
        logic [0:255] rkey;
        logic [1:0]   rlen;
        int           nr;

        sbox_tbl = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
                    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
                    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
                    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
                    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
                    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
                    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
                    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

        vecs[0] = '{{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 2'b00, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{{C128, 128'h0}, 2'b00, 128'h13111d7fe3944a17f307a78b4d2b30c5};
        vecs[2] = '{{C192, 64'h0},  2'b01, 128'ha4970a331a78dc09c418c271e3a41d5d};
        vecs[3] = '{C256,           2'b10, 128'h24fc79ccbf0979e9371ac23c6d68de36};
        vecs[4] = '{{8{32'hdeadbeef}}, 2'b11, 128'h0};

        reset_n_i = 1'b0;
        key_i = '0;
        key_len_i = 2'b00;
        v_i = 1'b0;
        yumi_i = 1'b0;
`ifdef KEY_EXPANSION_INV_EN
        dec_i = 1'b0;
`endif
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_reset_state("reset");
        reset_n_i = 1'b1;
        repeat (2) @(posedge clk_i);

        // Known-answer vectors, including the illegal key length.
        for (int v = 0; v < 5; v++) begin
            run_job(vecs[v].key, vecs[v].klen, 1'b0, $sformatf("vec%0d", v));
            nr = (vecs[v].klen == 2'b11) ? 0 : 10 + 2 * int'(vecs[v].klen);
            for (int g = 0; g < 3; g++)
                check($sformatf("vec%0d last round P%0d", v, 1 << g), rk_o[g][128*nr +: 128], vecs[v].last);
            if (v == 0) begin
                for (int g = 0; g < 3; g++)
                    check($sformatf("vec0 w43 P%0d", 1 << g), 128'(rk_o[g][32*43 +: 32]), 128'h b6630ca6);
            end
            release_job($sformatf("vec%0d", v));
        end

        // Back-pressure: hold the result 20 cycles while a new request is offered.
        run_job({C128, 128'h0}, 2'b00, 1'b0, "bp");
        for (int g = 0; g < 3; g++) snap[g] = fold(rk_o[g]);
        @(negedge clk_i);
        v_i = 1'b1;
        key_i = C256;
        key_len_i = 2'b10;
        repeat (20) begin
            @(posedge clk_i);
            #1;
            for (int g = 0; g < 3; g++) begin
                check($sformatf("bp v_o P%0d", 1 << g), 128'(v_o[g]), 128'(1));
                check($sformatf("bp ready P%0d", 1 << g), 128'(ready_o[g]), 128'(0));
                check($sformatf("bp keys P%0d", 1 << g), fold(rk_o[g]), snap[g]);
                check($sformatf("bp nr P%0d", 1 << g), 128'(nr_o[g]), 128'(10));
            end
        end
        @(negedge clk_i);
        v_i = 1'b0;
        release_job("bp");

        // Randomized jobs against the model.
        for (int n = 0; n < 12; n++) begin
            for (int k = 0; k < 8; k++) rkey[32*k +: 32] = $urandom;
            rlen = 2'($urandom_range(0, 3));
            run_job(rkey, rlen, 1'b0, $sformatf("rand%0d", n));
            release_job($sformatf("rand%0d", n));
        end

        // Reset in the middle of an AES-256 expansion.
        @(negedge clk_i);
        key_i = C256;
        key_len_i = 2'b10;
        v_i = 1'b1;
        @(posedge clk_i);
        #1;
        v_i = 1'b0;
        repeat (19) @(posedge clk_i);
        #2;
        reset_n_i = 1'b0;
        #1;
        check_reset_state("midreset");
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        for (int g = 0; g < 3; g++) check($sformatf("midreset no v_o P%0d", 1 << g), 128'(v_o[g]), 128'(0));
        run_job({C128, 128'h0}, 2'b00, 1'b0, "postreset");
        release_job("postreset");

`ifdef KEY_EXPANSION_INV_EN
        run_job({C128, 128'h0}, 2'b00, 1'b1, "inv");
        for (int g = 0; g < 3; g++) begin
            check($sformatf("inv round10 P%0d", 1 << g), rk_o[g][1280 +: 128], 128'h13111d7fe3944a17f307a78b4d2b30c5);
            check($sformatf("inv round0 P%0d", 1 << g), rk_o[g][0 +: 128], C128);
        end
        release_job("inv");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
